// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Sequencer that scans a sequence buffer from address 0 to len-1 by driving
//   an external enable/clear address counter. It issues memory read strobes,
//   tracks the read latency through a LAT-deep tag pipeline, and tags the
//   returned data with valid/last. Completion uses a start/busy/done handshake.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   start, len     : begin a scan of len words (sampled in IDLE only)
//   pause          : freeze address issue while high
//   abort          : cancel the scan in progress
//   cnt_en/cnt_clr : increment / clear to the external counter
//   cnt_q          : external counter value
//   mem_rd_en      : memory read strobe, mem_addr = cnt_q
//   mem_rdata      : memory read data (LAT cycles after mem_rd_en)
//   dat_out        : mem_rdata passthrough
//   dat_valid/last : dat_out valid / final word of the scan
//   busy, done     : scan in progress / one-cycle completion pulse
module seq_scan_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned LAT    = 1,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              pause,
    input  logic              abort,
    output logic              cnt_en,
    output logic              cnt_clr,
    input  logic [ADDR_W-1:0] cnt_q,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] dat_out,
    output logic              dat_valid,
    output logic              dat_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] len_r;
    logic [LAT-1:0]    pipe_v;
    logic [LAT-1:0]    pipe_l;
    logic              at_end;
    logic              last_tag;
    logic              kill;

    assign mem_addr  = cnt_q;
    assign dat_out   = mem_rdata;
    assign dat_valid = pipe_v[LAT-1];
    assign dat_last  = pipe_l[LAT-1];

    // Counter sits on the final address; the issue here is the last read.
    assign at_end = (cnt_q == len_r - ADDR_W'(1));
    // abort only acts outside IDLE, so start wins when both arrive in IDLE.
    assign kill   = abort && (state != S_IDLE);

    always_comb begin
        state_nx  = state;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        mem_rd_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (len != '0) ? S_CLR : S_DONE;
                end
            end
            S_CLR: begin
                cnt_clr  = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                mem_rd_en = ~pause;
                // Counter holds on the last address so mem_addr never wraps.
                cnt_en    = ~pause & ~at_end;
                if (~pause && at_end) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dat_valid && dat_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides every other decision made above.
        if (kill) begin
            state_nx  = S_IDLE;
            cnt_clr   = 1'b1;
            cnt_en    = 1'b0;
            mem_rd_en = 1'b0;
            done      = 1'b0;
        end
    end

    assign last_tag = mem_rd_en & at_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            len_r  <= '0;
            pipe_v <= '0;
            pipe_l <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start && len != '0) begin
                len_r <= len;
            end
            if (kill) begin
                pipe_v <= '0;
                pipe_l <= '0;
            end else begin
                pipe_v[0] <= mem_rd_en;
                pipe_l[0] <= last_tag;
                for (int unsigned i = 1; i < LAT; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                    pipe_l[i] <= pipe_l[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl
//   Drives two seq_scan_ctrl instances (LAT=1 and LAT=3) with identical
//   stimulus, each attached to its own counter and latency-matched memory.
//   Expected behaviour comes from a schedule model: the list of cycles in
//   which a read is issued, derived from start/pause/abort and len.
module tb_seq_scan_ctrl;

    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int MAXC = 6000;

    logic clk = 1'b0;
    logic reset, start, pause, abort;
    logic [AW-1:0] len;

    logic          cnt_en[2], cnt_clr[2], mem_rd_en[2];
    logic          dat_valid[2], dat_last[2], busy[2], done[2];
    logic [AW-1:0] cnt_q[2], mem_addr[2];
    logic [DW-1:0] mem_rdata[2], dat_out[2];

    int lat_of[2] = '{1, 3};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.ADDR_W(AW), .LAT(1), .DATA_W(DW)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .len(len), .pause(pause),
        .abort(abort), .cnt_en(cnt_en[0]), .cnt_clr(cnt_clr[0]), .cnt_q(cnt_q[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .dat_out(dat_out[0]), .dat_valid(dat_valid[0]), .dat_last(dat_last[0]),
        .busy(busy[0]), .done(done[0])
    );

    seq_scan_ctrl #(.ADDR_W(AW), .LAT(3), .DATA_W(DW)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .len(len), .pause(pause),
        .abort(abort), .cnt_en(cnt_en[1]), .cnt_clr(cnt_clr[1]), .cnt_q(cnt_q[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .dat_out(dat_out[1]), .dat_valid(dat_valid[1]), .dat_last(dat_last[1]),
        .busy(busy[1]), .done(done[1])
    );

    // External counters: clear has priority over enable, shared reset.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset || cnt_clr[k]) cnt_q[k] <= '0;
            else if (cnt_en[k])      cnt_q[k] <= cnt_q[k] + 1'b1;
        end
    end

    // Memories with 1- and 3-cycle read latency.
    logic [DW-1:0] mem [0:2047];
    logic [AW-1:0] ap1;
    logic [AW-1:0] ap3 [0:2];
    always @(posedge clk) begin
        ap1    <= mem_addr[0];
        ap3[0] <= mem_addr[1];
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
    end
    always_comb begin
        mem_rdata[0] = mem[ap1];
        mem_rdata[1] = mem[ap3[2]];
    end

    // Schedule model state.
    bit pat  [MAXC];
    bit iss  [MAXC];
    int iaddr[MAXC];
    int cur_len;
    int last_c;
    int abort_c;

    // Reads go out from the first RUN cycle (start cycle + 2), one per
    // unpaused cycle, addresses in order, none at or after an abort.
    task automatic model();
        int cnt;
        last_c = -1;
        for (int c = 0; c < MAXC; c++) begin
            iss[c]   = 1'b0;
            iaddr[c] = 0;
        end
        cnt = 0;
        if (cur_len > 0) begin
            for (int c = 2; c < MAXC && cnt < cur_len; c++) begin
                if (abort_c >= 0 && c >= abort_c) break;
                if (!pat[c]) begin
                    iss[c]   = 1'b1;
                    iaddr[c] = cnt;
                    cnt++;
                    if (cnt == cur_len) last_c = c;
                end
            end
        end
    endtask

    task automatic plan(input int ln, input int pause_pct, input int ab);
        cur_len = ln;
        abort_c = ab;
        for (int c = 0; c < MAXC; c++) pat[c] = ($urandom_range(99) < pause_pct);
        model();
    endtask

    // Runs one scan starting at cycle 0 and compares both DUTs every cycle.
    task automatic scan(input string name, input bit noise, input bit ab_at_start);
        int done_c[2], end_c[2];
        int cand, maxend, minend, ncyc, lt;
        bit ev;
        logic [6:0] exp_v, obs_v;
        for (int k = 0; k < 2; k++) begin
            lt = lat_of[k];
            if (cur_len == 0)   cand = 1;
            else if (last_c < 0) cand = MAXC;
            else                cand = last_c + lt + 1;
            if (abort_c >= 1 && abort_c <= cand) begin
                done_c[k] = -1;
                end_c[k]  = abort_c;
            end else begin
                done_c[k] = cand;
                end_c[k]  = cand;
            end
        end
        maxend = (end_c[0] > end_c[1]) ? end_c[0] : end_c[1];
        minend = (end_c[0] < end_c[1]) ? end_c[0] : end_c[1];
        ncyc   = maxend + 4;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (noise && c >= 1 && c <= minend && $urandom_range(3) == 0);
            if (c == 0)     len = AW'(cur_len);
            else if (noise) len = AW'($urandom);
            pause = pat[c];
            abort = (c == abort_c) || (c == 0 && ab_at_start)
                  || (noise && c > maxend && $urandom_range(2) == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                lt = lat_of[k];
                ev = (c >= lt) ? iss[c-lt] : 1'b0;
                if (done_c[k] < 0 && c > abort_c) ev = 1'b0;
                exp_v = {iss[c] && (iaddr[c] != cur_len - 1),
                         (c == 1 && cur_len != 0) || (done_c[k] < 0 && c == abort_c),
                         iss[c],
                         ev,
                         ev && (c - lt == last_c),
                         (c >= 1 && c <= end_c[k]),
                         (c == done_c[k])};
                obs_v = {cnt_en[k], cnt_clr[k], mem_rd_en[k], dat_valid[k],
                         dat_last[k], busy[k], done[k]};
                n_checks++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s ctl lat%0d cyc %0d: {en,clr,rd,vld,last,busy,done} got %b want %b",
                             name, lt, c, obs_v, exp_v);
                end
                if (iss[c]) begin
                    n_checks++;
                    if (mem_addr[k] !== AW'(iaddr[c])) begin
                        n_fail++;
                        $display("FAIL %s addr lat%0d cyc %0d: got %0d want %0d",
                                 name, lt, c, mem_addr[k], iaddr[c]);
                    end
                end
                if (ev) begin
                    n_checks++;
                    if (dat_out[k] !== mem[iaddr[c-lt]]) begin
                        n_fail++;
                        $display("FAIL %s data lat%0d cyc %0d: got %h want %h",
                                 name, lt, c, dat_out[k], mem[iaddr[c-lt]]);
                    end
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({cnt_en[k], cnt_clr[k], mem_rd_en[k], dat_valid[k], dat_last[k],
                 busy[k], done[k]} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset lat%0d: outputs got %b want 0", lat_of[k],
                         {cnt_en[k], cnt_clr[k], mem_rd_en[k], dat_valid[k],
                          dat_last[k], busy[k], done[k]});
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        plan(4, 0, -1);
        scan("basic", 1'b0, 1'b0);
    endtask

    task automatic test_pause();
        plan(4, 0, -1);
        pat[3] = 1'b1;
        pat[4] = 1'b1;
        model();
        scan("pause", 1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        plan(0, 50, -1);
        scan("zero_len", 1'b0, 1'b0);
    endtask

    task automatic test_max_len();
        plan(2047, 5, -1);
        scan("max_len", 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        plan(10, 0, 4);
        scan("abort_run", 1'b0, 1'b0);
        plan(2, 0, -1);
        scan("after_abort", 1'b0, 1'b0);
        plan(3, 0, -1);
        scan("abort_with_start", 1'b0, 1'b1);
        plan(0, 0, 1);
        scan("abort_in_done", 1'b0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        plan(5, 20, -1);
        scan("busy_start_len", 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [6:0] obs;
        start = 1'b1; len = AW'(5); pause = 1'b0; abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0);
            reset = (c == 5);
        end
        // reset was sampled at the end of cycle 5; check the following cycles
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                obs = {cnt_en[k], cnt_clr[k], mem_rd_en[k], dat_valid[k],
                       dat_last[k], busy[k], done[k]};
                n_checks++;
                if (obs !== 7'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid lat%0d cyc +%0d: outputs got %b want 0",
                             lat_of[k], c, obs);
                end
            end
        end
        plan(3, 10, -1);
        scan("after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int ln, ab;
        for (int s = 0; s < 25; s++) begin
            ln = $urandom_range(40);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(ln + 8, 1)) : -1;
            plan(ln, 30, ab);
            scan("random", 1'b1, 1'b0);
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = DW'($urandom);
        test_reset();
        test_basic();
        test_pause();
        test_zero_len();
        test_max_len();
        test_abort();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
